// File: rtl/kernel_job_port.sv
// Kernel-side job port: one pending descriptor slot, launch FSM with run timeout, held completion word.
// Launch two cycles after descriptor accept; engine_ready low while the slot is full, completion held until accepted.
module kernel_job_port #(
   parameter int          HOST_DWIDTH    = 1024,
   parameter int          PASID_WIDTH    = 9,
   parameter int          RETURN_WIDTH   = 41,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    engine_start,
   input  logic [HOST_DWIDTH-1:0]  engine_data,
   output logic                    engine_ready,
   output logic                    complete_ready,
   output logic [RETURN_WIDTH-1:0] complete_data,
   input  logic                    complete_accept,
   output logic                    kernel_start,
   output logic [HOST_DWIDTH-1:0]  kernel_dsc,
   input  logic                    kernel_done,
   input  logic [31:0]             kernel_status,
   output logic                    kernel_abort,
   output logic                    busy,
   output logic                    protocol_err,
   output logic [31:0]             jobs_done
);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_pend_vld;
   logic [HOST_DWIDTH-1:0]  r_pend_dat;
   logic                    r_cmp_vld;
   logic [RETURN_WIDTH-1:0] r_cmp_dat;
   logic [HOST_DWIDTH-1:0]  r_dsc;
   logic [PASID_WIDTH-1:0]  r_pasid;
   logic [31:0]             r_cnt;
   logic                    r_kstart;
   logic                    r_kabort;
   logic                    r_err;
   logic [31:0]             r_jobs;

   logic                    w_launch;
   logic                    w_done;
   logic                    w_timeout;
   logic                    w_pend_wr;
   logic                    w_cmp_rd;
   logic                    w_err;

   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_done      = 1'b0;
      w_timeout   = 1'b0;
      w_pend_wr   = engine_start && !r_pend_vld;
      w_cmp_rd    = complete_accept && r_cmp_vld;
      w_err       = (engine_start && r_pend_vld) ||
                    (complete_accept && !r_cmp_vld) ||
                    (kernel_done && (r_state == ST_IDLE));
      case (r_state)
         ST_IDLE: begin
            // An accept in this cycle frees the completion register for the job about to launch.
            if (r_pend_vld && (!r_cmp_vld || complete_accept)) begin
               w_launch    = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (kernel_done) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if ((TIMEOUT_CYCLES != 32'd0) && (r_cnt == TIMEOUT_CYCLES - 32'd1)) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_vld <= 1'b0;
         r_pend_dat <= '0;
         r_cmp_vld  <= 1'b0;
         r_cmp_dat  <= '0;
         r_dsc      <= '0;
         r_pasid    <= '0;
         r_cnt      <= '0;
         r_kstart   <= 1'b0;
         r_kabort   <= 1'b0;
         r_err      <= 1'b0;
         r_jobs     <= '0;
      end else begin
         r_kstart <= w_launch;
         r_kabort <= w_timeout;

         if (w_pend_wr) begin
            r_pend_vld <= 1'b1;
            r_pend_dat <= engine_data;
         end else if (w_launch) begin
            r_pend_vld <= 1'b0;
         end

         if (w_launch) begin
            r_dsc   <= r_pend_dat;
            r_pasid <= r_pend_dat[PASID_WIDTH-1:0];
            r_cnt   <= '0;
         end else if ((r_state == ST_RUN) && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
         end

         if (w_done || w_timeout) begin
            r_cmp_vld <= 1'b1;
            r_cmp_dat <= {r_pasid, (w_done ? kernel_status : 32'h8000_0001)};
            r_jobs    <= r_jobs + 32'd1;
         end else if (w_cmp_rd) begin
            r_cmp_vld <= 1'b0;
         end

         if (w_err) r_err <= 1'b1;
      end
   end

   assign engine_ready   = !r_pend_vld;
   assign complete_ready = r_cmp_vld;
   assign complete_data  = r_cmp_dat;
   assign kernel_start   = r_kstart;
   assign kernel_dsc     = r_dsc;
   assign kernel_abort   = r_kabort;
   assign busy           = (r_state == ST_RUN);
   assign protocol_err   = r_err;
   assign jobs_done      = r_jobs;

endmodule
